// File: rtl/alu_pkg.sv
// Shared definitions for the sequential shift/rotate ALU slice:
// opcode encodings, FSM state type and default operand width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OPCODE_SLL           = 3'b011;
  localparam logic [2:0] OPCODE_SAR           = 3'b100;
  localparam logic [2:0] OPCODE_ROTATIONLEFT  = 3'b101;
  localparam logic [2:0] OPCODE_ROTATIONRIGHT = 3'b110;
  localparam logic [2:0] OPCODE_SRL           = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_e;

  function automatic logic is_rotate(input logic [2:0] op);
    return (op == OPCODE_ROTATIONLEFT) || (op == OPCODE_ROTATIONRIGHT);
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OPCODE_SLL) || (op == OPCODE_SRL) || (op == OPCODE_SAR);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One bounded shift/rotate step: moves data by k positions (0..STEP) in
// the direction and with the fill selected by op.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] shifted
);

  logic [31:0] amt;
  logic [31:0] back;

  assign amt  = 32'(k);
  // With k=0 the wrap-around term shifts by WIDTH and vanishes, so rotates
  // need no special case.
  assign back = 32'(WIDTH) - amt;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    shifted = data;
    case (op)
      OPCODE_SLL:           shifted = data << amt;
      OPCODE_SRL:           shifted = data >> amt;
      OPCODE_SAR:           shifted = $signed(data) >>> amt;
      OPCODE_ROTATIONLEFT:  shifted = (data << amt) | (data >> back);
      OPCODE_ROTATIONRIGHT: shifted = (data >> amt) | (data << back);
      default:              shifted = data;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit with valid/ready request and response
// channels; moves at most STEP bit positions per enabled clock.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1            // power of two, 1..WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int KW = $clog2(STEP + 1);

  localparam logic [CW-1:0]    CNT_FULL   = CW'(WIDTH);
  localparam logic [CW-1:0]    STEP_CNT   = CW'(STEP);
  localparam logic [KW-1:0]    STEP_K     = KW'(STEP);
  localparam logic [WIDTH-1:0] WIDTH_OPER = WIDTH'(WIDTH);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CW-1:0]    acc_cnt;
  logic [KW-1:0]    step_k;
  logic [WIDTH-1:0] step_out;

  // Effective count at acceptance: shifts saturate at WIDTH, rotates wrap.
  always_comb begin
    acc_cnt = '0;
    if (is_shift(opcode)) begin
      acc_cnt = (B >= WIDTH_OPER) ? CNT_FULL : CW'(B);
    end else if (is_rotate(opcode)) begin
      acc_cnt = CW'(B % WIDTH_OPER);
    end
  end

  assign step_k = (cnt_q < STEP_CNT) ? KW'(cnt_q) : STEP_K;

  alu_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data    (data_q),
    .op      (op_q),
    .k       (step_k),
    .shifted (step_out)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = data_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_d    = opcode;
            cnt_d   = acc_cnt;
            // Illegal opcodes report zero and skip straight to DONE.
            data_d  = (is_shift(opcode) || is_rotate(opcode)) ? A : '0;
            state_d = (acc_cnt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          data_d = step_out;
          cnt_d  = cnt_q - CW'(step_k);
          if (cnt_d == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench: STEP=1 and STEP=4 instances share stimulus and are
// compared against an arithmetic reference model.
module tb_alu_shift_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, in_valid, out_ready;
  logic [15:0] a, b;
  logic [2:0]  opcode;
  logic        in_ready1, out_valid1, in_ready4, out_valid4;
  logic [15:0] result1, result4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_shift_seq #(.WIDTH(16), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a), .B(b), .opcode(opcode), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1)
  );

  alu_shift_seq #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready4),
    .A(a), .B(b), .opcode(opcode), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic int model_cnt(input logic [15:0] bv, input logic [2:0] op);
    if (op == OPCODE_SLL || op == OPCODE_SRL || op == OPCODE_SAR)
      return (int'(bv) >= 16) ? 16 : int'(bv);
    if (op == OPCODE_ROTATIONLEFT || op == OPCODE_ROTATIONRIGHT)
      return int'(bv) % 16;
    return 0;
  endfunction

  function automatic int model_lat(input int cnt, input int step);
    return (cnt == 0) ? 1 : (cnt + step - 1) / step + 1;
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] av, input int n);
    int x;
    x = int'(av);
    return 16'(x * (1 << n) + x / (1 << (16 - n)));
  endfunction

  function automatic logic [15:0] model_res(input logic [15:0] av,
                                            input logic [15:0] bv,
                                            input logic [2:0] op);
    int n, d, s, q;
    n = model_cnt(bv, op);
    d = 1 << n;
    case (op)
      OPCODE_SLL: return 16'(int'(av) * d);
      OPCODE_SRL: return 16'(int'(av) / d);
      OPCODE_SAR: begin
        s = av[15] ? int'(av) - 65536 : int'(av);
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        return 16'(q);
      end
      OPCODE_ROTATIONLEFT:  return rol16(av, n);
      OPCODE_ROTATIONRIGHT: return rol16(av, (16 - n) % 16);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic run_txn(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [2:0] op, input logic [15:0] exp_res,
                         input int gap, input int hold, input bit spam);
    int lat, l1, l4, exp1, exp4;
    bit d1, d4, busy_ok, stable;
    logic [15:0] snap1, snap4;
    exp1 = model_lat(model_cnt(bv, op), 1);
    exp4 = model_lat(model_cnt(bv, op), 4);
    if (gap > 0 && exp1 > gap) exp1 += 3;
    if (gap > 0 && exp4 > gap) exp4 += 3;

    @(negedge clk);
    check({tag, " in_ready idle"}, {in_ready1, in_ready4}, 2'b11);
    a = av; b = bv; opcode = op; in_valid = 1'b1; en = 1'b1; out_ready = 1'b0;
    lat = 0; l1 = 0; l4 = 0; d1 = 0; d4 = 0; busy_ok = 1;
    while (!(d1 && d4) && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = spam;
      if (spam) begin
        a = 16'($urandom); b = 16'($urandom); opcode = 3'($urandom);
      end
      en = !(gap > 0 && lat >= gap && lat < gap + 3);
      if (!d1) begin
        if (out_valid1) begin d1 = 1; l1 = lat; end
        else if (in_ready1) busy_ok = 0;
      end
      if (!d4) begin
        if (out_valid4) begin d4 = 1; l4 = lat; end
        else if (in_ready4) busy_ok = 0;
      end
    end
    en = 1'b1;
    check({tag, " completed"}, {d1, d4}, 2'b11);
    check({tag, " in_ready low while busy"}, busy_ok, 1);
    check({tag, " result step1"}, result1, exp_res);
    check({tag, " result step4"}, result4, exp_res);
    check({tag, " latency step1"}, l1, exp1);
    check({tag, " latency step4"}, l4, exp4);

    if (hold > 0) begin
      snap1 = result1; snap4 = result4; stable = 1;
      repeat (hold) begin
        @(negedge clk);
        if (!(out_valid1 && out_valid4 && !in_ready1 && !in_ready4 &&
              result1 === snap1 && result4 === snap4)) stable = 0;
      end
      check({tag, " backpressure hold"}, stable, 1);
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " after handshake"}, {out_valid1, out_valid4, in_ready1, in_ready4}, 4'b0011);
    check({tag, " result held in idle"}, {result1, result4}, {exp_res, exp_res});
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] exp;
    int          gap;
    int          hold;
    bit          spam;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{16'h0001, 16'd4,     OPCODE_SLL,           16'h0010, 0, 0, 1'b0};
    vecs[1]  = '{16'h8000, 16'd3,     OPCODE_SAR,           16'hF000, 0, 0, 1'b0};
    vecs[2]  = '{16'h8000, 16'd3,     OPCODE_SRL,           16'h1000, 0, 0, 1'b0};
    vecs[3]  = '{16'h8000, 16'd20,    OPCODE_SAR,           16'hFFFF, 0, 0, 1'b0};
    vecs[4]  = '{16'h8001, 16'd1,     OPCODE_ROTATIONLEFT,  16'h0003, 0, 0, 1'b0};
    vecs[5]  = '{16'h8001, 16'd17,    OPCODE_ROTATIONRIGHT, 16'hC000, 0, 0, 1'b0};
    vecs[6]  = '{16'h8001, 16'd16,    OPCODE_ROTATIONLEFT,  16'h8001, 0, 0, 1'b0};
    vecs[7]  = '{16'h1234, 16'd5,     3'b000,               16'h0000, 0, 0, 1'b0};
    vecs[8]  = '{16'h0001, 16'd10,    OPCODE_SLL,           16'h0400, 0, 0, 1'b0};
    vecs[9]  = '{16'h8421, 16'hFFFF,  OPCODE_SAR,           16'hFFFF, 0, 0, 1'b0};
    vecs[10] = '{16'h1234, 16'd0,     OPCODE_SLL,           16'h1234, 0, 0, 1'b0};
    vecs[11] = '{16'hABCD, 16'd7,     OPCODE_SRL,           16'h0157, 2, 0, 1'b0};
    vecs[12] = '{16'h00F1, 16'd4,     OPCODE_ROTATIONRIGHT, 16'h100F, 0, 5, 1'b0};
    vecs[13] = '{16'hFFFF, 16'd16,    OPCODE_SLL,           16'h0000, 0, 0, 1'b1};
    vecs[14] = '{16'h1234, 16'd32,    OPCODE_ROTATIONLEFT,  16'h1234, 0, 0, 1'b0};
    vecs[15] = '{16'hFFFF, 16'd15,    OPCODE_SRL,           16'h0001, 0, 0, 1'b0};

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; opcode = '0;
    #12;
    check("reset handshake outputs", {in_ready1, out_valid1, in_ready4, out_valid4}, 4'b1010);
    check("reset result", {result1, result4}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp,
              vecs[i].gap, vecs[i].hold, vecs[i].spam);
    end

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    a = 16'h00FF; b = 16'd16; opcode = OPCODE_SLL; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset mid-shift", {out_valid1, out_valid4, in_ready1, in_ready4}, 4'b0011);
    check("async reset result", {result1, result4}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("post-reset", 16'h0F0F, 16'd5, OPCODE_ROTATIONLEFT, 16'hE1E1, 0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      logic [2:0]  rop;
      int          rgap;
      rop  = 3'($urandom_range(0, 7));
      ra   = 16'($urandom);
      rb   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      rgap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_txn($sformatf("rand%0d", i), ra, rb, rop, model_res(ra, rb, rop),
              rgap, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
